dcache_dm_wt: RTL and testbench
===============================

// Module: dcache_dm_wt
// PURPOSE
//  Data cache responding to the MEM stage's read/write/byte-enable/address/wdata request; returns rdata + ready.
//  Direct-mapped, write-through, no-write-allocate, one-entry write buffer; refills lines from backing memory.
//  The MEM stage stalls while a request is held and ready is low.
// PARAMETERS
//  NUM_LINES       64  cache lines, power of 2
//  WORDS_PER_LINE  4   32-bit words per line, power of 2 (>=2)
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   synchronous, active-low reset
//  en_read_in      in   1   load request, held until ready
//  en_write_in     in   1   store request, held until ready
//  byte_en_in      in   4   store byte lanes; bit i = byte [8i+7:8i]
//  addr_in         in   32  byte address; [1:0] ignored
//  wdata_in        in   32  store data
//  rdata_out       out  32  load data, valid when ready_out && en_read_in
//  ready_out       out  1   combinational; request completes at this edge
//  mem_req_out     out  1   backing-memory request, held until mem_ack_in
//  mem_we_out      out  1   1 = write beat, 0 = read beat
//  mem_addr_out    out  32  word-aligned beat address
//  mem_be_out      out  4   write byte lanes (4'b1111 on reads)
//  mem_wdata_out   out  32  write data
//  mem_rdata_in    in   32  read data, valid with mem_ack_in
//  mem_ack_in      in   1   one beat done; no ack without mem_req_out
// BEHAVIOUR
//  Address split: offset[1:0], word = next log2(WORDS_PER_LINE) bits, index = next log2(NUM_LINES) bits, tag = rest.
//  State per line: valid bit, tag, data words. FSM: IDLE, WB_WAIT, REFILL.
//  Read hit (IDLE, valid && tag match): ready_out=1 in the same cycle; rdata_out = array word, combinational.
//  Read miss in IDLE: ready_out=0. Write buffer full -> WB_WAIT, else -> REFILL with beat=0.
//  WB_WAIT: stay until the buffer drains (ack), then -> REFILL.
//  REFILL: mem_req=1, we=0, addr={tag,index,beat,2'b00}. Each ack writes mem_rdata_in to word[beat] and does beat++.
//   On the last ack: set valid and tag, -> IDLE. The held read then hits the next cycle.
//   Miss-to-ready latency = WORDS_PER_LINE acks + 1 cycle.
//  Write, IDLE: ready_out = 1 iff the write buffer is empty. At that edge:
//   capture {addr, byte_en, wdata} into the buffer.
//   On a hit, also merge the enabled bytes into the array.
//   A miss does not allocate and leaves valid/tag unchanged.
//  Write buffer full: mem_req=1, we=1, driving its addr/be/wdata, held stable until ack; ack empties it.
//   A new write may be accepted the cycle after the ack.
//  Priority: write-buffer drain before refill. One memory transaction outstanding at a time.
//  Outside IDLE, ready_out=0 for every request.
//  en_read_in && en_write_in together is illegal: handled as a read, write ignored.
//  No request (both enables low): ready_out=0, no state change.
//  Beat counter wraps to 0 after the last beat. Index aliasing replaces the line (no victim writeback needed).
//  Reset (any state, including mid-refill or with a pending drain): all valid=0, FSM=IDLE, buffer empty, beat=0.
//   Outputs after reset: ready_out=0, mem_req_out=0, mem_we_out=0, mem_addr_out=0, mem_be_out=0, mem_wdata_out=0.
//   rdata_out is don't-care (driven from the array). Data arrays are not reset.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs hit_count_out[31:0] and miss_count_out[31:0], both reset to 0.
//   hit: +1 on each completing read hit.
//   miss: +1 on each IDLE->WB_WAIT/REFILL transition.
//   Both counters saturate at 32'hFFFF_FFFF.
//  DCACHE_STATS_EN undefined: no counter ports, no counter logic; behaviour otherwise identical.
// TESTING
//  Cold read 0x100, ack every cycle -> 4 beats at 0x100/104/108/10C, we=0. ready 1 cycle after the last ack; rdata = beat-0 data.
//  Read 0x104 right after the fill -> ready=1 same cycle, rdata = beat-1 data, mem_req_out=0.
//  Store 0x108, be=4'b0011, wdata=0xAABBCCDD onto a resident word 0x11223344:
//   ready same cycle; mem beat we=1, be=0011; later read 0x108 returns 0x1122CCDD.
//  Store miss 0x2000 with mem_ack delayed 5 cycles, then read 0x2000:
//   the write beat completes first, then the refill starts; valid was not set by the store.
//  Back-to-back stores with a slow ack -> the second store sees ready=0 until the cycle after the first store's ack.
//  rst_n=0 after beat 2 of a refill -> next cycle mem_req_out=0; read of the same address misses and refills from beat 0.

Source files
------------

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a one-entry write buffer.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_dm_wt #(
   parameter int NUM_LINES      = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_read_in,
   input  logic        en_write_in,
   input  logic [3:0]  byte_en_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   output logic [31:0] rdata_out,
   output logic        ready_out,
   output logic        mem_req_out,
   output logic        mem_we_out,
   output logic [31:0] mem_addr_out,
   output logic [3:0]  mem_be_out,
   output logic [31:0] mem_wdata_out,
   input  logic [31:0] mem_rdata_in,
   input  logic        mem_ack_in
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count_out,
   output logic [31:0] miss_count_out
`endif
);

   localparam int WW = $clog2(WORDS_PER_LINE);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = 32 - 2 - WW - IW;

   typedef enum logic [1:0] {IDLE, WB_WAIT, REFILL} state_t;

   state_t            state_q;
   logic [WW-1:0]     beat_q;
   logic [NUM_LINES-1:0] valid_q;
   logic [TW-1:0]     tag_q  [NUM_LINES];
   logic [31:0]       data_q [NUM_LINES*WORDS_PER_LINE];

   logic              wb_valid_q;
   logic [29:0]       wb_addr_q;
   logic [3:0]        wb_be_q;
   logic [31:0]       wb_data_q;

   logic [WW-1:0]     reqWord;
   logic [IW-1:0]     reqIdx;
   logic [TW-1:0]     reqTag;
   logic              isRead, isWrite, hit, lastBeat, acceptWrite;
   logic [1:0]        unused_addr;

   assign reqWord     = addr_in[2 +: WW];
   assign reqIdx      = addr_in[2+WW +: IW];
   assign reqTag      = addr_in[31 -: TW];
   assign unused_addr = addr_in[1:0];

   // A simultaneous read and write is treated as a read only.
   assign isRead      = en_read_in;
   assign isWrite     = en_write_in && !en_read_in;
   assign hit         = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
   assign lastBeat    = (beat_q == WW'(WORDS_PER_LINE-1));
   assign acceptWrite = (state_q == IDLE) && isWrite && !wb_valid_q;

   assign ready_out = (state_q == IDLE) && ((isRead && hit) || (isWrite && !wb_valid_q));
   assign rdata_out = data_q[{reqIdx, reqWord}];

   // The write buffer always owns the memory port first; a refill only runs once it is empty.
   always_comb begin
      mem_req_out   = 1'b0;
      mem_we_out    = 1'b0;
      mem_addr_out  = '0;
      mem_be_out    = '0;
      mem_wdata_out = '0;
      if (wb_valid_q) begin
         mem_req_out   = 1'b1;
         mem_we_out    = 1'b1;
         mem_addr_out  = {wb_addr_q, 2'b00};
         mem_be_out    = wb_be_q;
         mem_wdata_out = wb_data_q;
      end else if (state_q == REFILL) begin
         mem_req_out   = 1'b1;
         mem_addr_out  = {reqTag, reqIdx, beat_q, 2'b00};
         mem_be_out    = 4'b1111;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         valid_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_be_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         if (wb_valid_q && mem_ack_in) begin
            wb_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (isRead && !hit) begin
                  state_q <= wb_valid_q ? WB_WAIT : REFILL;
                  beat_q  <= '0;
               end else if (acceptWrite) begin
                  wb_valid_q <= 1'b1;
                  wb_addr_q  <= addr_in[31:2];
                  wb_be_q    <= byte_en_in;
                  wb_data_q  <= wdata_in;
               end
            end
            WB_WAIT: begin
               if (!wb_valid_q || mem_ack_in) begin
                  state_q <= REFILL;
               end
            end
            REFILL: begin
               if (mem_ack_in) begin
                  beat_q <= beat_q + WW'(1);
                  if (lastBeat) begin
                     valid_q[reqIdx] <= 1'b1;
                     state_q         <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and data storage carry no reset; only the valid bits are cleared.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == REFILL && mem_ack_in) begin
            data_q[{reqIdx, beat_q}] <= mem_rdata_in;
            if (lastBeat) begin
               tag_q[reqIdx] <= reqTag;
            end
         end else if (acceptWrite && hit) begin
            for (int i = 0; i < 4; i++) begin
               if (byte_en_in[i]) begin
                  data_q[{reqIdx, reqWord}][8*i +: 8] <= wdata_in[8*i +: 8];
               end
            end
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_q, miss_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else if (state_q == IDLE && isRead) begin
         if (hit && hit_count_q != 32'hFFFF_FFFF) begin
            hit_count_q <= hit_count_q + 32'd1;
         end
         if (!hit && miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign hit_count_out  = hit_count_q;
   assign miss_count_out = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Directed self-checking bench for dcache_dm_wt with a behavioural backing memory.
module tb_dcache_dm_wt;

   logic        clk;
   logic        rst_n;
   logic        en_read_in;
   logic        en_write_in;
   logic [3:0]  byte_en_in;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic [31:0] rdata_out;
   logic        ready_out;
   logic        mem_req_out;
   logic        mem_we_out;
   logic [31:0] mem_addr_out;
   logic [3:0]  mem_be_out;
   logic [31:0] mem_wdata_out;
   logic [31:0] mem_rdata_in;
   logic        mem_ack_in;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } beat_t;

   beat_t       beatLog[$];
   logic [31:0] memArr[logic [31:0]];
   int          ackDelay = 0;
   int          waitCnt  = 0;

   dcache_dm_wt dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_read_in   (en_read_in),
      .en_write_in  (en_write_in),
      .byte_en_in   (byte_en_in),
      .addr_in      (addr_in),
      .wdata_in     (wdata_in),
      .rdata_out    (rdata_out),
      .ready_out    (ready_out),
      .mem_req_out  (mem_req_out),
      .mem_we_out   (mem_we_out),
      .mem_addr_out (mem_addr_out),
      .mem_be_out   (mem_be_out),
      .mem_wdata_out(mem_wdata_out),
      .mem_rdata_in (mem_rdata_in),
      .mem_ack_in   (mem_ack_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unwritten memory words read back as {16'hCAFE, addr[15:0]}.
   function automatic logic [31:0] memRead(input logic [31:0] a);
      logic [31:0] v;
      if (memArr.exists(a)) v = memArr[a];
      else v = {16'hCAFE, a[15:0]};
      return v;
   endfunction

   // Backing memory: answers each beat after ackDelay waiting cycles, logging every beat.
   always @(negedge clk) begin
      logic [31:0] v;
      beat_t       b;
      mem_ack_in   = 1'b0;
      mem_rdata_in = '0;
      if (mem_req_out && rst_n) begin
         if (waitCnt >= ackDelay) begin
            waitCnt    = 0;
            mem_ack_in = 1'b1;
            v = memRead(mem_addr_out);
            if (mem_we_out) begin
               for (int i = 0; i < 4; i++)
                  if (mem_be_out[i]) v[8*i +: 8] = mem_wdata_out[8*i +: 8];
               memArr[mem_addr_out] = v;
               b.data = mem_wdata_out;
            end else begin
               mem_rdata_in = v;
               b.data = v;
            end
            b.we   = mem_we_out;
            b.addr = mem_addr_out;
            b.be   = mem_be_out;
            beatLog.push_back(b);
         end else begin
            waitCnt++;
         end
      end else begin
         waitCnt = 0;
      end
   end

   // Presents one request and holds it until ready; cycles = not-ready cycles, -1 on timeout.
   task automatic doAccess(input logic rd, input logic wr, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int cycles);
      bit done;
      @(negedge clk);
      en_read_in  = rd;
      en_write_in = wr;
      byte_en_in  = be;
      addr_in     = addr;
      wdata_in    = wdata;
      cycles      = 0;
      rdata       = '0;
      done        = 0;
      while (!done && cycles < 500) begin
         #1;
         if (ready_out) begin
            rdata = rdata_out;
            done  = 1;
         end else begin
            cycles++;
            @(negedge clk);
         end
      end
      if (done) @(posedge clk);
      else cycles = -1;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      en_read_in  = 1'b0;
      en_write_in = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en_read_in = 1'b0; en_write_in = 1'b0;
      byte_en_in = '0; addr_in = '0; wdata_in = '0;
      repeat (3) @(negedge clk);
      checks++; if (ready_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", ready_out); end
      checks++; if (mem_req_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", mem_req_out); end
      checks++; if (mem_we_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", mem_we_out); end
      checks++; if (mem_addr_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", mem_addr_out); end
      checks++; if (mem_be_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_be got %h want 0", mem_be_out); end
      checks++; if (mem_wdata_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata got %h want 0", mem_wdata_out); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_cold_read();
      logic [31:0] rd;
      int cyc, start;
      memArr[32'h108] = 32'h1122_3344;
      ackDelay = 0;
      start = beatLog.size();
      doAccess(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, rd, cyc);
      checks++; if (cyc != 5) begin errors++; $display("[TB] FAIL cold_latency got %0d want 5", cyc); end
      checks++; if (rd !== 32'hCAFE_0100) begin errors++; $display("[TB] FAIL cold_rdata got %h want cafe0100", rd); end
      checks++; if (beatLog.size() != start + 4) begin errors++; $display("[TB] FAIL cold_beats got %0d want 4", beatLog.size() - start); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (beatLog[start+i].we !== 1'b0 || beatLog[start+i].addr !== 32'h100 + 32'(4*i) || beatLog[start+i].be !== 4'hF) begin
            errors++;
            $display("[TB] FAIL cold_beat%0d got we=%b addr=%h be=%h want we=0 addr=%h be=f", i,
                     beatLog[start+i].we, beatLog[start+i].addr, beatLog[start+i].be, 32'h100 + 32'(4*i));
         end
      end
   endtask

   task automatic test_read_hit();
      logic [31:0] rd;
      int cyc, start;
      start = beatLog.size();
      doAccess(1'b1, 1'b0, 4'h0, 32'h104, 32'h0, rd, cyc);
      checks++; if (cyc != 0) begin errors++; $display("[TB] FAIL hit_latency got %0d want 0", cyc); end
      checks++; if (rd !== 32'hCAFE_0104) begin errors++; $display("[TB] FAIL hit_rdata got %h want cafe0104", rd); end
      idle(1);
      checks++; if (mem_req_out !== 1'b0 || beatLog.size() != start) begin errors++; $display("[TB] FAIL hit_no_mem got req=%b beats=%0d want req=0 beats=0", mem_req_out, beatLog.size() - start); end
   endtask

   task automatic test_store_hit();
      logic [31:0] rd;
      int cyc, start;
      ackDelay = 0;
      start = beatLog.size();
      doAccess(1'b0, 1'b1, 4'b0011, 32'h108, 32'hAABB_CCDD, rd, cyc);
      checks++; if (cyc != 0) begin errors++; $display("[TB] FAIL store_latency got %0d want 0", cyc); end
      doAccess(1'b1, 1'b0, 4'h0, 32'h108, 32'h0, rd, cyc);
      checks++; if (cyc != 0 || rd !== 32'h1122_CCDD) begin errors++; $display("[TB] FAIL store_merge got cyc=%0d rdata=%h want cyc=0 rdata=1122ccdd", cyc, rd); end
      idle(3);
      checks++;
      if (beatLog.size() != start + 1 || beatLog[start].we !== 1'b1 || beatLog[start].addr !== 32'h108 ||
          beatLog[start].be !== 4'b0011 || beatLog[start].data !== 32'hAABB_CCDD) begin
         errors++;
         $display("[TB] FAIL store_beat got n=%0d we=%b addr=%h be=%h data=%h want n=1 we=1 addr=108 be=3 data=aabbccdd",
                  beatLog.size() - start, beatLog[start].we, beatLog[start].addr, beatLog[start].be, beatLog[start].data);
      end
      checks++; if (memRead(32'h108) !== 32'h1122_CCDD) begin errors++; $display("[TB] FAIL store_mem got %h want 1122ccdd", memRead(32'h108)); end
   endtask

   task automatic test_store_miss();
      logic [31:0] rd;
      int cyc, start;
      ackDelay = 5;
      start = beatLog.size();
      doAccess(1'b0, 1'b1, 4'hF, 32'h2000, 32'h1234_5678, rd, cyc);
      checks++; if (cyc != 0) begin errors++; $display("[TB] FAIL miss_store_latency got %0d want 0", cyc); end
      doAccess(1'b1, 1'b0, 4'h0, 32'h2000, 32'h0, rd, cyc);
      checks++; if (cyc != 30) begin errors++; $display("[TB] FAIL miss_read_latency got %0d want 30", cyc); end
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("[TB] FAIL miss_read_rdata got %h want 12345678", rd); end
      checks++; if (beatLog.size() != start + 5) begin errors++; $display("[TB] FAIL miss_beats got %0d want 5", beatLog.size() - start); end
      checks++;
      if (beatLog[start].we !== 1'b1 || beatLog[start].addr !== 32'h2000 ||
          beatLog[start+1].we !== 1'b0 || beatLog[start+1].addr !== 32'h2000) begin
         errors++;
         $display("[TB] FAIL miss_order got %b@%h then %b@%h want 1@2000 then 0@2000",
                  beatLog[start].we, beatLog[start].addr, beatLog[start+1].we, beatLog[start+1].addr);
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int cyc, start;
      ackDelay = 3;
      start = beatLog.size();
      doAccess(1'b0, 1'b1, 4'hF, 32'h300, 32'h0000_0001, rd, cyc);
      checks++; if (cyc != 0) begin errors++; $display("[TB] FAIL b2b_first got %0d want 0", cyc); end
      doAccess(1'b0, 1'b1, 4'hF, 32'h304, 32'h0000_0002, rd, cyc);
      checks++; if (cyc != 4) begin errors++; $display("[TB] FAIL b2b_second got %0d want 4", cyc); end
      idle(10);
      checks++;
      if (beatLog.size() != start + 2 || beatLog[start].addr !== 32'h300 || beatLog[start].data !== 32'h1 ||
          beatLog[start+1].addr !== 32'h304 || beatLog[start+1].data !== 32'h2) begin
         errors++;
         $display("[TB] FAIL b2b_beats got n=%0d %h/%h %h/%h want n=2 300/1 304/2", beatLog.size() - start,
                  beatLog[start].addr, beatLog[start].data, beatLog[start+1].addr, beatLog[start+1].data);
      end
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] rd;
      int cyc, start;
      bit reached;
      ackDelay = 0;
      start = beatLog.size();
      reached = 0;
      @(negedge clk);
      en_read_in = 1'b1; en_write_in = 1'b0; addr_in = 32'h400;
      for (int i = 0; i < 50 && !reached; i++) begin
         @(posedge clk);
         #1;
         if (beatLog.size() == start + 2) reached = 1;
      end
      checks++; if (!reached) begin errors++; $display("[TB] FAIL rst_mid_reach got beats=%0d want 2", beatLog.size() - start); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (mem_req_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_req got %b want 0", mem_req_out); end
      checks++; if (beatLog.size() != start + 2) begin errors++; $display("[TB] FAIL rst_mid_beats got %0d want 2", beatLog.size() - start); end
      en_read_in = 1'b0;
      rst_n = 1'b1;
      start = beatLog.size();
      doAccess(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, rd, cyc);
      checks++; if (cyc != 5) begin errors++; $display("[TB] FAIL rst_mid_refetch got %0d want 5", cyc); end
      checks++; if (beatLog[start].addr !== 32'h400) begin errors++; $display("[TB] FAIL rst_mid_beat0 got %h want 400", beatLog[start].addr); end
      checks++; if (rd !== 32'hCAFE_0400) begin errors++; $display("[TB] FAIL rst_mid_rdata got %h want cafe0400", rd); end
   endtask

   task automatic test_alias_and_dual();
      logic [31:0] rd;
      int cyc, start;
      ackDelay = 0;
      doAccess(1'b1, 1'b0, 4'h0, 32'h500, 32'h0, rd, cyc);
      checks++; if (cyc != 5 || rd !== 32'hCAFE_0500) begin errors++; $display("[TB] FAIL alias_fill got cyc=%0d rdata=%h want 5 cafe0500", cyc, rd); end
      doAccess(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, rd, cyc);
      checks++; if (cyc != 5 || rd !== 32'hCAFE_0100) begin errors++; $display("[TB] FAIL alias_evict got cyc=%0d rdata=%h want 5 cafe0100", cyc, rd); end
      start = beatLog.size();
      doAccess(1'b1, 1'b1, 4'hF, 32'h104, 32'hFFFF_FFFF, rd, cyc);
      checks++; if (cyc != 0 || rd !== 32'hCAFE_0104) begin errors++; $display("[TB] FAIL dual_read got cyc=%0d rdata=%h want 0 cafe0104", cyc, rd); end
      idle(3);
      checks++; if (beatLog.size() != start) begin errors++; $display("[TB] FAIL dual_no_write got beats=%0d want 0", beatLog.size() - start); end
      doAccess(1'b1, 1'b0, 4'h0, 32'h104, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hCAFE_0104) begin errors++; $display("[TB] FAIL dual_unchanged got %h want cafe0104", rd); end
      idle(1);
   endtask

   initial begin
      rst_n = 1'b0;
      en_read_in = 1'b0; en_write_in = 1'b0;
      byte_en_in = '0; addr_in = '0; wdata_in = '0;
      test_reset();
      test_cold_read();
      test_read_hit();
      test_store_hit();
      test_store_miss();
      test_back_to_back();
      test_reset_mid_refill();
      test_alias_and_dual();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
